// File: rtl/pn_pkg.sv
// Shared types for the Polish Notation job scheduler: controller states,
// evaluator mode codes and the buffered token format.
package pn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    ERR
  } state_e;

  localparam logic [1:0] PRE_SORT   = 2'd0;
  localparam logic [1:0] POST_SORT  = 2'd1;
  localparam logic [1:0] PRE_STACK  = 2'd2;
  localparam logic [1:0] POST_STACK = 2'd3;

  typedef struct packed {
    logic       operator;
    logic [2:0] value;
  } token_t;

endpackage

// File: rtl/pn_rr_arbiter.sv
// Round-robin request picker: first requester at or above ptr, wrapping.
// Purely combinational; the pointer register lives in the parent.
module pn_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  int  j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/pn_job_scheduler.sv
// Shares one Polish Notation evaluator among NUM_REQ clients: round-robin grant,
// whole-job token buffering, result counting with client tagging and a timeout.
module pn_job_scheduler
  import pn_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MAX_TOK = 12,
  parameter int TIMEOUT = 64,
  parameter int GAP     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [2*NUM_REQ-1:0]   req_mode,
  input  logic [NUM_REQ-1:0]     req_operator,
  input  logic [3*NUM_REQ-1:0]   req_in,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [1:0]             pn_mode,
  output logic                   pn_operator,
  output logic [2:0]             pn_in,
  output logic                   pn_in_valid,
  input  logic                   pn_out_valid,
  input  logic [31:0]            pn_out,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_data,
  output logic                   rsp_last,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int CNT_W = $clog2(MAX_TOK + 1);
  localparam int IDX_W = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP + 2);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d, gid_q, gid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, icnt_q, icnt_d, exp_q, exp_d, rcnt_q, rcnt_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         mode_q, mode_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  token_t             buf_q [MAX_TOK];
  logic               pn_in_valid_q, pn_in_valid_d;
  logic [1:0]         pn_mode_q, pn_mode_d;
  token_t             pn_tok_q, pn_tok_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d, rsp_err_q, rsp_err_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic signed [31:0] rsp_data_q, rsp_data_d;

  logic               sel_valid, sel_last, buf_we;
  logic [1:0]         sel_mode, tok_mode;
  token_t             sel_tok;
  logic [IDX_W-1:0]   buf_widx;
  logic [CNT_W-1:0]   cnt_fin, exp_fin;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;

  pn_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Mux the granted client's token lane down to a single view.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_mode  = '0;
    sel_tok   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == ID_W'(i)) begin
        sel_valid        = req_valid[i];
        sel_last         = req_last[i];
        sel_mode         = req_mode[2*i +: 2];
        sel_tok.operator = req_operator[i];
        sel_tok.value    = req_in[3*i +: 3];
      end
    end
  end

  assign buf_we   = (state_q == LOAD) && sel_valid && (cnt_q != CNT_W'(MAX_TOK));
  assign buf_widx = IDX_W'(cnt_q);

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_widx] <= sel_tok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gid_q         <= '0;
      cnt_q         <= '0;
      icnt_q        <= '0;
      exp_q         <= '0;
      rcnt_q        <= '0;
      ovf_q         <= 1'b0;
      mode_q        <= '0;
      timer_q       <= '0;
      gap_q         <= '0;
      pn_in_valid_q <= 1'b0;
      pn_mode_q     <= '0;
      pn_tok_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_last_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gid_q         <= gid_d;
      cnt_q         <= cnt_d;
      icnt_q        <= icnt_d;
      exp_q         <= exp_d;
      rcnt_q        <= rcnt_d;
      ovf_q         <= ovf_d;
      mode_q        <= mode_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      pn_in_valid_q <= pn_in_valid_d;
      pn_mode_q     <= pn_mode_d;
      pn_tok_q      <= pn_tok_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_last_q    <= rsp_last_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gid_d         = gid_q;
    cnt_d         = cnt_q;
    icnt_d        = icnt_q;
    exp_d         = exp_q;
    rcnt_d        = rcnt_q;
    ovf_d         = ovf_q;
    mode_d        = mode_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    pn_in_valid_d = 1'b0;
    pn_mode_d     = '0;
    pn_tok_d      = '0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = '0;
    rsp_data_d    = '0;
    rsp_last_d    = 1'b0;
    rsp_err_d     = 1'b0;
    tok_mode      = '0;
    cnt_fin       = '0;
    exp_fin       = '0;
    case (state_q)
      IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (|arb_gnt) begin
          gid_d   = arb_idx;
          ptr_d   = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (sel_valid) begin
          tok_mode = (cnt_q == '0) ? sel_mode : mode_q;
          mode_d   = tok_mode;
          // A full buffer keeps accepting so the client can finish, but flags the job.
          if (cnt_q == CNT_W'(MAX_TOK)) begin
            ovf_d   = 1'b1;
            cnt_fin = cnt_q;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            cnt_fin = cnt_q + 1'b1;
          end
          if (sel_last) begin
            exp_fin = (tok_mode == PRE_STACK || tok_mode == POST_STACK) ?
                      CNT_W'(1) : cnt_fin / CNT_W'(3);
            exp_d   = exp_fin;
            icnt_d  = '0;
            state_d = (ovf_d || exp_fin == '0) ? ERR : ISSUE;
          end
        end
      end
      ISSUE: begin
        pn_in_valid_d = 1'b1;
        pn_mode_d     = mode_q;
        pn_tok_d      = buf_q[IDX_W'(icnt_q)];
        icnt_d        = icnt_q + 1'b1;
        if (icnt_q + 1'b1 == cnt_q) begin
          state_d = WAIT;
          rcnt_d  = '0;
          timer_d = '0;
        end
      end
      WAIT: begin
        if (pn_out_valid) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = gid_q;
          rsp_data_d  = $signed(pn_out);
          rsp_last_d  = (rcnt_q + 1'b1 == exp_q);
          rcnt_d      = rcnt_q + 1'b1;
          timer_d     = '0;
          if (rsp_last_d) begin
            state_d = IDLE;
            gap_d   = GAP_W'(GAP);
          end
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_d == TMR_W'(TIMEOUT)) state_d = ERR;
        end
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_last_d  = 1'b1;
        rsp_id_d    = gid_q;
        state_d     = IDLE;
        gap_d       = GAP_W'(GAP);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q == LOAD && gid_q == ID_W'(i)) req_ready[i] = 1'b1;
    end
    busy = (state_q != IDLE);
  end

  assign pn_in_valid = pn_in_valid_q;
  assign pn_mode     = pn_mode_q;
  assign pn_operator = pn_tok_q.operator;
  assign pn_in       = pn_tok_q.value;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_last    = rsp_last_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_pn_job_scheduler.sv
// Bench for pn_job_scheduler: queued client jobs, an evaluator stand-in, and a
// job-level model of grants, token bursts and tagged responses.
module tb_pn_job_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MAX_TOK = 12;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 2;

  typedef struct packed { logic [1:0] mode; logic op; logic [2:0] val; logic last; } ctok_t;
  typedef struct packed { logic [1:0] mode; logic op; logic [2:0] val; } pntok_t;
  typedef struct packed { logic [ID_W-1:0] id; logic [31:0] data; logic last; logic err; int kind; int tref; } ersp_t;
  typedef struct packed { int dly; logic [31:0] val; logic extra; logic last; } pulse_t;

  logic                 clk, rst_n;
  logic [NUM_REQ-1:0]   req_valid, req_ready, req_operator, req_last;
  logic [2*NUM_REQ-1:0] req_mode;
  logic [3*NUM_REQ-1:0] req_in;
  logic [1:0]           pn_mode;
  logic                 pn_operator, pn_in_valid, pn_out_valid;
  logic [2:0]           pn_in;
  logic [31:0]          pn_out, rsp_data;
  logic                 rsp_valid, rsp_last, rsp_err, busy;
  logic [ID_W-1:0]      rsp_id;

  pn_job_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_TOK(MAX_TOK),
                     .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_operator(req_operator), .req_in(req_in), .req_last(req_last),
    .pn_mode(pn_mode), .pn_operator(pn_operator), .pn_in(pn_in),
    .pn_in_valid(pn_in_valid), .pn_out_valid(pn_out_valid), .pn_out(pn_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_pass, cyc;
  ctok_t  cq [NUM_REQ][$];
  pntok_t pnq[$];
  ersp_t  rq[$];
  pulse_t plq[$];
  logic [31:0] eng_vals[$];
  int     grant_log[$];
  int     mptr, cur_gid, cur_exp, low_run;
  bit     in_load, eng_silent, rst_in_issue, had_burst, prev_pn;
  logic [NUM_REQ-1:0] prev_req;

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] r);
    for (int k = 0; k < NUM_REQ; k++) begin
      int j = (mptr + k) % NUM_REQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic add_tok(input int c, input logic [1:0] m, input logic o, input logic [2:0] v, input logic l);
    ctok_t t;
    t.mode = m; t.op = o; t.val = v; t.last = l;
    cq[c].push_back(t);
  endtask

  task automatic add_job(input int c, input logic [1:0] m, input int len);
    for (int k = 0; k < len; k++)
      add_tok(c, (k == 0) ? m : 2'($urandom), 1'($urandom), 3'($urandom), k == len - 1);
  endtask

  // Job-level expectation from the granted client's queued tokens.
  task automatic start_job(input int g);
    int len, ex;
    logic [1:0] m;
    pntok_t p;
    ersp_t e;
    len = 0;
    cur_gid = g;
    mptr = (g + 1) % NUM_REQ;
    if (cq[g].size() == 0) begin
      chk("grant_empty_client", 1, 0);
      return;
    end
    m = cq[g][0].mode;
    for (int k = 0; k < cq[g].size(); k++) begin
      len = k + 1;
      if (cq[g][k].last) break;
    end
    ex = (m >= 2) ? 1 : len / 3;
    cur_exp = ex;
    if (len > MAX_TOK || ex == 0) begin
      e = '{id: ID_W'(g), data: 32'd0, last: 1'b1, err: 1'b1, kind: 1, tref: 0};
      rq.push_back(e);
    end else begin
      for (int k = 0; k < len; k++) begin
        p.mode = m; p.op = cq[g][k].op; p.val = cq[g][k].val;
        pnq.push_back(p);
      end
    end
  endtask

  task automatic burst_done();
    pulse_t pl;
    ersp_t e;
    if (eng_silent) begin
      e = '{id: ID_W'(cur_gid), data: 32'd0, last: 1'b1, err: 1'b1, kind: 2, tref: cyc};
      rq.push_back(e);
    end else begin
      for (int k = 0; k < cur_exp; k++) begin
        pl.dly = int'($urandom_range(0, 4));
        pl.val = (eng_vals.size() > 0) ? eng_vals.pop_front() : $urandom;
        pl.extra = 1'b0;
        pl.last = (k == cur_exp - 1);
        plq.push_back(pl);
      end
      if ($urandom_range(0, 1) == 1) begin
        pl.dly = 1; pl.val = $urandom; pl.extra = 1'b1; pl.last = 1'b0;
        plq.push_back(pl);
      end
    end
  endtask

  task automatic monitor();
    ersp_t e;
    if (req_ready != '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i] && !in_load) grant_log.push_back(i);
      if (!in_load) begin
        int eg = pick(prev_req);
        if (eg < 0) chk("grant_without_request", req_ready, 0);
        else begin
          chk("grant", req_ready, 1 << eg);
          start_job(eg);
        end
        in_load = 1'b1;
      end else begin
        chk("ready_gid", req_ready, 1 << cur_gid);
      end
      if (req_ready[cur_gid] && req_valid[cur_gid] && req_last[cur_gid]) in_load = 1'b0;
    end
    if (pn_in_valid) begin
      if (!prev_pn && had_burst) chk("pn_gap", low_run >= GAP, 1);
      had_burst = 1'b1;
      low_run = 0;
      if (pnq.size() == 0) chk("pn_unexpected", 1, 0);
      else begin
        chk("pn_tok", {pn_mode, pn_operator, pn_in}, pnq[0]);
        void'(pnq.pop_front());
        if (pnq.size() == 0) burst_done();
      end
    end else begin
      if (prev_pn && pnq.size() != 0) chk("pn_burst_break", pnq.size(), 0);
      low_run++;
    end
    prev_pn = pn_in_valid;
    if (rsp_valid) begin
      if (rq.size() == 0) chk("rsp_unexpected", rsp_data, 0);
      else begin
        e = rq.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_last", rsp_last, e.last);
        chk("rsp_err", rsp_err, e.err);
        if (e.kind == 0) chk("rsp_lat", cyc, e.tref);
        else if (e.kind == 2) chk("timeout_lat", (cyc - e.tref >= TIMEOUT) && (cyc - e.tref <= TIMEOUT + 3), 1);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pn", {pn_in_valid, pn_mode, pn_operator, pn_in}, 0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_last, rsp_err}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ctl", {busy, req_ready}, 0);
    for (int i = 0; i < NUM_REQ; i++) cq[i].delete();
    pnq.delete(); rq.delete(); plq.delete(); eng_vals.delete();
    mptr = 0; in_load = 1'b0; had_burst = 1'b0; prev_pn = 1'b0; rst_in_issue = 1'b0;
    req_valid = '0; pn_out_valid = 1'b0; prev_req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] hs;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_mode[2*i +: 2] = cq[i][0].mode;
        req_operator[i] = cq[i][0].op;
        req_in[3*i +: 3] = cq[i][0].val;
        req_last[i] = cq[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
        req_mode[2*i +: 2] = 2'($urandom);
        req_operator[i] = 1'($urandom);
        req_in[3*i +: 3] = 3'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    pn_out_valid = 1'b0;
    pn_out = $urandom;
    if (plq.size() > 0) begin
      if (plq[0].dly == 0) begin
        pn_out_valid = 1'b1;
        pn_out = plq[0].val;
        if (!plq[0].extra)
          rq.push_back('{id: ID_W'(cur_gid), data: plq[0].val, last: plq[0].last, err: 1'b0, kind: 0, tref: cyc + 1});
        void'(plq.pop_front());
      end else begin
        plq[0].dly = plq[0].dly - 1;
      end
    end
    #1;
    monitor();
    if (rst_in_issue && pn_in_valid) begin
      do_reset();
      return;
    end
    hs = req_valid & req_ready;
    for (int i = 0; i < NUM_REQ; i++) if (hs[i]) void'(cq[i].pop_front());
    prev_req = req_valid;
  endtask

  function automatic bit idle_all();
    bit q_empty = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (cq[i].size() != 0) q_empty = 1'b0;
    return q_empty && pnq.size() == 0 && rq.size() == 0 && plq.size() == 0 && !busy && !in_load;
  endfunction

  task automatic run_phase(input string name, input int budget);
    int n = 0;
    tick();
    while (!idle_all() && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done"}, idle_all(), 1);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    mptr = 0; in_load = 0; eng_silent = 0; rst_in_issue = 0; had_burst = 0; prev_pn = 0;
    low_run = 0; cur_gid = 0; cur_exp = 0; prev_req = '0;
    rst_n = 1'b0;
    req_valid = '0; req_mode = '0; req_operator = '0; req_in = '0; req_last = '0;
    pn_out_valid = 1'b0; pn_out = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pn", {pn_in_valid, pn_mode, pn_operator, pn_in}, 0);
    chk("reset_rsp", {rsp_valid, rsp_id, rsp_last, rsp_err}, 0);
    chk("reset_ctl", {busy, req_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Client 0, mode 3: 3 4 add -> 7.
    add_tok(0, 2'd3, 1'b0, 3'd3, 1'b0);
    add_tok(0, 2'd1, 1'b0, 3'd4, 1'b0);
    add_tok(0, 2'd0, 1'b1, 3'd0, 1'b1);
    eng_vals.push_back(32'd7);
    run_phase("single", 500);

    // Client 1, mode 0, six tokens -> two results.
    add_job(1, 2'd0, 6);
    eng_vals.push_back(32'd9);
    eng_vals.push_back(32'd5);
    run_phase("two_results", 500);

    add_job(3, 2'd2, 2);
    run_phase("align_ptr", 500);

    // Contention with held requests; client 0 queues a second job.
    grant_log.delete();
    add_job(0, 2'd2, 3);
    add_job(0, 2'd3, 4);
    add_job(2, 2'd0, 3);
    add_job(3, 2'd1, 9);
    run_phase("rr", 2000);
    chk("rr_grants", grant_log.size(), 4);
    for (int k = 0; k < grant_log.size() && k < 4; k++) begin
      int want [4] = '{0, 2, 3, 0};
      chk("rr_order", grant_log[k], want[k]);
    end

    add_job(2, 2'd0, 14);
    run_phase("overflow", 500);

    add_job(1, 2'd0, 2);
    run_phase("no_results", 500);

    eng_silent = 1'b1;
    add_job(1, 2'd2, 5);
    run_phase("timeout", 500);
    eng_silent = 1'b0;
    chk("timeout_busy", busy, 0);

    // Reset mid-burst, then requests from 1 and 3 must start from pointer 0.
    rst_in_issue = 1'b1;
    add_job(2, 2'd1, 6);
    run_phase("reset_issue", 500);
    repeat (5) tick();
    grant_log.delete();
    add_job(3, 2'd2, 3);
    add_job(1, 2'd3, 3);
    run_phase("post_reset", 1000);
    chk("post_reset_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);

    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 6; j++)
        add_job(int'($urandom_range(0, NUM_REQ - 1)), 2'($urandom), int'($urandom_range(1, 14)));
      run_phase("random", 4000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pn_job_scheduler.md
Name: pn_job_scheduler

Overview:
- Shares one Polish Notation evaluator (serial token input, 1–4 signed 32-bit results out) among NUM_REQ client ports.
- Grants clients round-robin and buffers each job's tokens so the evaluator sees an unbroken in_valid burst.
- Counts the results the evaluator should return, tags them with the client id, and guards each job with a timeout.

Parameters:
NUM_REQ, 4, number of client ports (2..8)
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ
MAX_TOK, 12, token buffer depth (maximum job length)
TIMEOUT, 64, cycles in WAIT without pn_out_valid before the job is aborted
GAP, 2, idle cycles forced on pn_in_valid between consecutive jobs

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  client i presents a token
req_ready  out  NUM_REQ  token accepted (granted client, LOAD state only)
req_mode  in  2*NUM_REQ  job mode; sampled with the client's first token
req_operator  in  NUM_REQ  1 = operator token, 0 = operand token
req_in  in  3*NUM_REQ  token value
req_last  in  NUM_REQ  marks the final token of the job
pn_mode  out  2  mode sent to the evaluator
pn_operator  out  1  token type sent to the evaluator
pn_in  out  3  token value sent to the evaluator
pn_in_valid  out  1  evaluator input strobe
pn_out_valid  in  1  evaluator result strobe
pn_out  in  32  evaluator result, signed
rsp_valid  out  1  response strobe
rsp_id  out  ID_W  client id that owns the response
rsp_data  out  32  result value, signed
rsp_last  out  1  final response of the job
rsp_err  out  1  job aborted (overflow, underflow or timeout)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state = IDLE. All outputs 0. RR pointer = 0. Token count = 0. GAP counter = 0. Reset asserted mid-job abandons the job; no response is emitted.
- IDLE:
  - Wait until the GAP counter reaches 0.
  - Grant the first client i with req_valid=1, searching from ptr upward and wrapping.
  - Latch gid = i. Set ptr = i+1 mod NUM_REQ. Go to LOAD. No token is accepted in the grant cycle.
- LOAD:
  - req_ready[gid] = 1. Each req_valid[gid] cycle writes one token into buffer[cnt] and increments cnt.
  - The first accepted token latches mode.
  - Tokens beyond MAX_TOK are accepted and dropped, and ovf is set.
  - On an accepted token with req_last=1, compute exp:
    - mode 0/1: exp = cnt_final / 3
    - mode 2/3: exp = 1
  - Then:
    - If ovf = 1 or exp = 0: go to ERR.
    - Otherwise: go to ISSUE.
- ISSUE:
  - pn_in_valid = 1 for exactly cnt consecutive cycles, driving buffer[0..cnt-1] in order.
  - pn_mode = latched mode for the whole burst.
  - The outputs are registered: the first token appears one cycle after entering ISSUE.
  - Afterwards pn_in_valid = 0. Go to WAIT with rcnt = 0 and timer = 0.
- WAIT:
  - Each pn_out_valid pulse produces, one cycle later: rsp_valid=1, rsp_id=gid, rsp_data=pn_out, rsp_err=0, rsp_last=(rcnt+1==exp). Then rcnt increments.
  - Once rcnt reaches exp: go to IDLE and load the GAP counter.
  - pn_out_valid pulses after exp is reached are ignored.
  - timer resets on every pn_out_valid. If timer reaches TIMEOUT, go to ERR.
- ERR: one rsp_valid cycle with rsp_err=1, rsp_last=1, rsp_data=0, rsp_id=gid. Then go to IDLE and load the GAP counter.
- req_ready is never high for a non-granted client. Other clients hold their req_valid; a held request is never dropped.
- Fairness: a client that keeps req_valid high is granted within NUM_REQ jobs.
- Responses have no backpressure; the consumer must accept every rsp_valid.

Decomposition:
- Package pn_pkg:
  - state encodings IDLE/LOAD/ISSUE/WAIT/ERR
  - mode constants: PRE_SORT=0, POST_SORT=1, PRE_STACK=2, POST_STACK=3
  - token struct {operator, value[2:0]}
- One sub-module: pn_rr_arbiter (request vector + pointer -> one-hot grant and index; combinational, pointer register in the parent).

Test Plan:
- Client 0 sends mode 3 tokens 3,4,op0 (op0 = add) → pn_in_valid high 3 cycles in order; engine returns 7 → rsp_id=0, rsp_data=7, rsp_last=1, rsp_err=0.
- Client 1 sends mode 0 with 6 tokens → exp=2; engine returns 9 then 5 → two responses, rsp_id=1, rsp_last only on the second.
- Clients 0, 2, 3 all request and each holds req_valid across its job → grants in order 0, 2, 3, 0; req_ready never high for a non-granted client; pn_in_valid low for ≥GAP cycles between bursts.
- Client 2 sends 14 tokens → no pn_in_valid; one response with rsp_err=1, rsp_id=2, rsp_data=0.
- Mode 2 job with pn_out_valid never asserted → after TIMEOUT=64 cycles in WAIT, one error response, busy drops.
- rst_n asserted during ISSUE → all outputs 0 immediately, no response; the next job starts cleanly from ptr=0.
